// File: rtl/d_latch_checker.sv
// Self-test driver/checker for a d_latch: walks a fixed en/d sequence and counts q/q' mismatches.
// Optional: define LATCH_CHK_STOP_ON_ERR_EN to end the run on the first mismatching check.
module d_latch_checker #(
  parameter int NUM_STEPS     = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             q_in,
  input  logic             q_comp_in,
  output logic             en_out,
  output logic             d_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             pass_out,
  output logic [ERR_W-1:0] err_count_out
);

  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam int SC_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(NUM_STEPS - 1);
  localparam logic [SC_W-1:0]   SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  // IDLE: wait start | DRIVE: register stimulus | SETTLE: wait | CHECK: compare | DONE: report
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

`ifdef LATCH_CHK_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  logic [2:0]       state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [SC_W-1:0]  settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             en_q, en_d;
  logic             dd_q, dd_d;
  logic             exp_q_q, exp_q_d;
  logic             exp_valid_q, exp_valid_d;
  logic [2:0]       stim_bits;
  logic             stim_en, stim_d;
  logic             mismatch;

  // Steps narrower than 3 bits read the missing high bits as 0.
  assign stim_bits = 3'(step_q);
  assign stim_en   = stim_bits[1];
  assign stim_d    = stim_bits[0] ^ stim_bits[2];
  assign mismatch  = exp_valid_q && ((q_in != exp_q_q) || (q_comp_in != ~q_in));

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    settle_d    = settle_q;
    err_d       = err_q;
    en_d        = en_q;
    dd_d        = dd_q;
    exp_q_d     = exp_q_q;
    exp_valid_d = exp_valid_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          state_d     = S_DRIVE;
          step_d      = '0;
          err_d       = '0;
          exp_valid_d = 1'b0;
        end
      end
      S_DRIVE: begin
        en_d     = stim_en;
        dd_d     = stim_d;
        settle_d = SETTLE_LOAD;
        state_d  = S_SETTLE;
        if (stim_en) begin
          exp_q_d     = stim_d;
          exp_valid_d = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_CHECK;
        else                settle_d = settle_q - 1'b1;
      end
      S_CHECK: begin
        if (mismatch && (err_q != ERR_MAX)) err_d = err_q + 1'b1;
        if ((mismatch && STOP_ON_ERR) || (step_q == LAST_STEP)) begin
          state_d = S_DONE;
          en_d    = 1'b0;
        end else begin
          step_d  = step_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      settle_q    <= '0;
      err_q       <= '0;
      en_q        <= 1'b0;
      dd_q        <= 1'b0;
      exp_q_q     <= 1'b0;
      exp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      settle_q    <= settle_d;
      err_q       <= err_d;
      en_q        <= en_d;
      dd_q        <= dd_d;
      exp_q_q     <= exp_q_d;
      exp_valid_q <= exp_valid_d;
    end
  end

  assign en_out        = en_q;
  assign d_out         = dd_q;
  assign busy_out      = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done_out      = (state_q == S_DONE);
  assign pass_out      = done_out && (err_q == '0);
  assign err_count_out = err_q;

endmodule

// File: tb/tb_d_latch_checker.sv
// Bench for d_latch_checker: behavioural latch with injectable faults, step-level reference model.
module tb_d_latch_checker;
  localparam int N  = 8;
  localparam int S  = 2;
  localparam int EW = 8;
  localparam int SP = S + 2;
`ifdef LATCH_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic q, qc, en, d, busy, done, pass;
  logic [EW-1:0] err;
  logic lat_q = 1'b0;
  int fault_mode = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Ideal latch; fault 1 = q stuck 0, fault 2 = q' tied to q.
  always @(en, d) if (en) lat_q = d;
  assign q  = (fault_mode == 1) ? 1'b0 : lat_q;
  assign qc = (fault_mode == 2) ? q : ~q;

  d_latch_checker #(.NUM_STEPS(N), .SETTLE_CYCLES(S), .ERR_W(EW)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .q_in(q), .q_comp_in(qc),
    .en_out(en), .d_out(d), .busy_out(busy), .done_out(done), .pass_out(pass),
    .err_count_out(err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int fault, input int lat0, output int exp_err,
                                output int run_len, output int last_d);
    int lat, ex, valid, e, dd, qo, qco, cnt;
    lat = lat0; ex = 0; valid = 0; cnt = 0;
    run_len = N * SP; last_d = 0;
    for (int s = 0; s < N; s++) begin
      e  = (s >> 1) & 1;
      dd = (s & 1) ^ ((s >> 2) & 1);
      last_d = dd;
      if (e == 1) begin lat = dd; ex = dd; valid = 1; end
      qo  = (fault == 1) ? 0 : lat;
      qco = (fault == 2) ? qo : 1 - qo;
      if (valid == 1 && (qo != ex || qco != 1 - qo)) begin
        cnt++;
        if (STOP) begin run_len = (s + 1) * SP; break; end
      end
    end
    exp_err = (cnt > (1 << EW) - 1) ? (1 << EW) - 1 : cnt;
  endfunction

  task automatic run_once(input int fault, input int hold);
    int exp_err, len, last_d, s;
    fault_mode = fault;
    @(negedge clk);
    model(fault, int'(lat_q), exp_err, len, last_d);
    start = 1'b1;
    @(posedge clk); #1;
    if (hold <= 1) start = 1'b0;
    for (int cyc = 1; cyc <= len; cyc++) begin
      @(posedge clk); #1;
      if (cyc >= hold) start = 1'b0;
      if (cyc % SP == 1) begin
        s = cyc / SP;
        chk("step_en", int'(en), (s >> 1) & 1);
        chk("step_d", int'(d), (s & 1) ^ ((s >> 2) & 1));
        chk("step_busy", int'(busy), 1);
      end
      if (cyc == len - 1) chk("done_early", int'(done), 0);
    end
    start = 1'b0;
    chk("done", int'(done), 1);
    chk("busy_done", int'(busy), 0);
    chk("pass", int'(pass), (exp_err == 0) ? 1 : 0);
    chk("err_count", int'(err), exp_err);
    chk("en_done", int'(en), 0);
    chk("d_hold", int'(d), last_d);
  endtask

  initial begin
    int gap;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", int'(en), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);

    run_once(0, 1);
    run_once(1, 1);
    run_once(2, 1);
    run_once(0, 5);
    for (int r = 0; r < 5; r++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("done_stays", int'(done), 1);
      end
      run_once($urandom_range(0, 2), $urandom_range(1, 6));
    end

    // Abort during the SETTLE of step 4, then a clean rerun.
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4 * SP + 1) @(posedge clk);
    #1;
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_en", int'(en), 0);
    chk("abort_d", int'(d), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_err", int'(err), 0);
    run_once(0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
